// File: rtl/traffic_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | traffic_pkg : state codes and lamp encodings for the junction ctrl |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
package traffic_pkg;

  typedef enum logic [2:0] {
    S1    = 3'd0,
    S2    = 3'd1,
    S3    = 3'd2,
    S4    = 3'd3,
    NIGHT = 3'd4
  } state_t;

  // Lamp vectors are {red, yellow, green}
  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

endpackage
`default_nettype wire

// File: rtl/traffic_light_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | traffic_light_ctrl : two-road signal sequencer with ped shortening |
// | and flashing-yellow night mode, stepped by a 1 Hz tick. rev 1.0    |
// +--------------------------------------------------------------------+
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int G1_SEC  = 29,
  parameter int G2_SEC  = 19,
  parameter int Y_SEC   = 3,
  parameter int PED_SEC = 5,
  parameter int TW      = 6
) (
  input  logic          clk1h,
  input  logic          rst_n,
  input  logic          night_mode,
  input  logic          ped_req,
  output logic [2:0]    led1,
  output logic [2:0]    led2,
  output logic [TW-1:0] time_left,
  output logic [2:0]    state,
  output logic          ped_pend
);

  localparam logic [TW-1:0] c_G1_LOAD  = TW'(G1_SEC - 1);
  localparam logic [TW-1:0] c_G2_LOAD  = TW'(G2_SEC - 1);
  localparam logic [TW-1:0] c_Y_LOAD   = TW'(Y_SEC - 1);
  localparam logic [TW-1:0] c_PED_LOAD = TW'(PED_SEC - 1);
  localparam logic [TW-1:0] c_ONE      = TW'(1);

  state_t        r_state, w_state_nxt;
  logic [TW-1:0] r_time,  w_time_nxt;
  logic          r_ped,   w_ped_nxt;
  logic          r_flash, w_flash_nxt;
  logic          w_ped_any;

  always_ff @(posedge clk1h) begin
    if (!rst_n) begin
      r_state <= S1;
      r_time  <= c_G2_LOAD;
      r_ped   <= 1'b0;
      r_flash <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_ped   <= w_ped_nxt;
      r_flash <= w_flash_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_ped_nxt   = r_ped;
    w_flash_nxt = 1'b0;
    w_ped_any   = r_ped | ped_req;

    case (r_state)
      S1, S2, S3, S4: begin
        w_ped_nxt = w_ped_any;
        if (night_mode) begin
          w_state_nxt = NIGHT;
          w_time_nxt  = '0;
          w_ped_nxt   = 1'b0;
        end else if (r_time == '0) begin
          // Leaving a green phase serves the pending request; clear beats set
          case (r_state)
            S1: begin
              w_state_nxt = S2;
              w_time_nxt  = c_Y_LOAD;
              w_ped_nxt   = 1'b0;
            end
            S2: begin
              w_state_nxt = S3;
              w_time_nxt  = c_G1_LOAD;
            end
            S3: begin
              w_state_nxt = S4;
              w_time_nxt  = c_Y_LOAD;
              w_ped_nxt   = 1'b0;
            end
            default: begin
              w_state_nxt = S1;
              w_time_nxt  = c_G2_LOAD;
            end
          endcase
        end else if ((r_state == S1 || r_state == S3) && w_ped_any &&
                     (r_time > c_PED_LOAD)) begin
          w_time_nxt = c_PED_LOAD;
        end else begin
          w_time_nxt = r_time - c_ONE;
        end
      end
      NIGHT: begin
        w_ped_nxt = 1'b0;
        if (night_mode) begin
          w_time_nxt  = '0;
          w_flash_nxt = ~r_flash;
        end else begin
          w_state_nxt = S1;
          w_time_nxt  = c_G2_LOAD;
        end
      end
      default: begin
        w_state_nxt = S1;
        w_time_nxt  = c_G2_LOAD;
        w_ped_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    led1 = RED;
    led2 = GRN;
    case (r_state)
      S2: led2 = YEL;
      S3: begin
        led1 = GRN;
        led2 = RED;
      end
      S4: begin
        led1 = YEL;
        led2 = RED;
      end
      NIGHT: begin
        led1 = r_flash ? OFF : YEL;
        led2 = r_flash ? OFF : YEL;
      end
      default: begin
        led1 = RED;
        led2 = GRN;
      end
    endcase
  end

  assign time_left = r_time;
  assign state     = r_state;
  assign ped_pend  = r_ped;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_traffic_light_ctrl : vector table plus directed corner cases    |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_traffic_light_ctrl;

  logic       clk1h = 1'b0;
  logic       rst_n = 1'b0;
  logic       night_mode = 1'b0;
  logic       ped_req = 1'b0;
  logic [2:0] led1, led2;
  logic [5:0] time_left;
  logic [2:0] state;
  logic       ped_pend;

  int n_vec = 0;
  int n_err = 0;

  traffic_light_ctrl dut (
    .clk1h      (clk1h),
    .rst_n      (rst_n),
    .night_mode (night_mode),
    .ped_req    (ped_req),
    .led1       (led1),
    .led2       (led2),
    .time_left  (time_left),
    .state      (state),
    .ped_pend   (ped_pend)
  );

  always #5 clk1h = ~clk1h;

  typedef struct {
    logic       rst_n;
    logic       night;
    logic       ped;
    logic [2:0] st;
    logic [5:0] tl;
    logic [2:0] l1;
    logic [2:0] l2;
    logic       pp;
  } vec_t;

  vec_t tbl [17];

  task automatic tick(input logic r, input logic n, input logic p);
    rst_n      = r;
    night_mode = n;
    ped_req    = p;
    @(posedge clk1h);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] st, input logic [5:0] tl,
                       input logic [2:0] l1, input logic [2:0] l2, input logic pp);
    n_vec++;
    if (state !== st || time_left !== tl || led1 !== l1 || led2 !== l2 || ped_pend !== pp) begin
      n_err++;
      $display("FAIL %s: got st=%0d tl=%0d l1=%b l2=%b pp=%b, want st=%0d tl=%0d l1=%b l2=%b pp=%b",
               name, state, time_left, led1, led2, ped_pend, st, tl, l1, l2, pp);
    end
  endtask

  // Lamps for the daytime states: S1 100/001, S2 100/010, S3 001/100, S4 010/100
  function automatic logic [5:0] lamps(input logic [2:0] st);
    case (st)
      3'd0:    return 6'b100_001;
      3'd1:    return 6'b100_010;
      3'd2:    return 6'b001_100;
      3'd3:    return 6'b010_100;
      default: return 6'b010_010;
    endcase
  endfunction

  task automatic check_day(input string name, input logic [2:0] st, input logic [5:0] tl,
                           input logic pp);
    logic [5:0] l;
    l = lamps(st);
    check(name, st, tl, l[5:3], l[2:0], pp);
  endtask

  task automatic advance(input int n);
    for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [2:0] est;
    logic [5:0] etl;
    int         p;

    //            rst  ngt  ped  st    tl     l1      l2      pp
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 6'd18, 3'b100, 3'b001, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd17, 3'b100, 3'b001, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 3'd0, 6'd4,  3'b100, 3'b001, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd3,  3'b100, 3'b001, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd2,  3'b100, 3'b001, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd1,  3'b100, 3'b001, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd0,  3'b100, 3'b001, 1'b1};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd1, 6'd2,  3'b100, 3'b010, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 3'd1, 6'd1,  3'b100, 3'b010, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 6'd0,  3'b100, 3'b010, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd2, 6'd28, 3'b001, 3'b100, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd2, 6'd4,  3'b001, 3'b100, 1'b1};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 3'd4, 6'd0,  3'b010, 3'b010, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 3'd4, 6'd0,  3'b000, 3'b000, 1'b0};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 3'd4, 6'd0,  3'b010, 3'b010, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 3'd0, 6'd18, 3'b100, 3'b001, 1'b0};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 3'd0, 6'd18, 3'b100, 3'b001, 1'b0};

    for (int i = 0; i < 17; i++) begin
      tick(tbl[i].rst_n, tbl[i].night, tbl[i].ped);
      check($sformatf("vec%0d", i), tbl[i].st, tbl[i].tl, tbl[i].l1, tbl[i].l2, tbl[i].pp);
    end

    // Free-running full cycle: 19 + 3 + 29 + 3 ticks
    tick(1'b0, 1'b0, 1'b0);
    check_day("cycle_reset", 3'd0, 6'd18, 1'b0);
    for (p = 1; p <= 54; p++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (p <= 18)      begin est = 3'd0; etl = 6'(18 - p); end
      else if (p <= 21) begin est = 3'd1; etl = 6'(21 - p); end
      else if (p <= 50) begin est = 3'd2; etl = 6'(50 - p); end
      else if (p <= 53) begin est = 3'd3; etl = 6'(53 - p); end
      else              begin est = 3'd0; etl = 6'd18;      end
      check_day($sformatf("cycle_p%0d", p), est, etl, 1'b0);
    end

    // Pedestrian shortening in S3, then reset from S4 with a pending request
    tick(1'b0, 1'b0, 1'b0);
    advance(30);
    check_day("s3_t20", 3'd2, 6'd20, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s3_ped_load", 3'd2, 6'd4, 1'b1);
    for (int k = 3; k >= 0; k--) begin
      tick(1'b1, 1'b0, 1'b0);
      check_day($sformatf("s3_ped_cnt%0d", k), 3'd2, 6'(k), 1'b1);
    end
    tick(1'b1, 1'b0, 1'b0);
    check_day("s4_entry_clr", 3'd3, 6'd2, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s4_ped_set", 3'd3, 6'd1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    check_day("s4_reset", 3'd0, 6'd18, 1'b0);

    // Request held through S2 is served early in S3
    advance(19);
    check_day("s2_entry", 3'd1, 6'd2, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s2_hold1", 3'd1, 6'd1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s2_hold0", 3'd1, 6'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s3_entry_pend", 3'd2, 6'd28, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_day("s3_pend_load", 3'd2, 6'd4, 1'b1);

    // Request late in S1 (time_left already below the ped window)
    tick(1'b0, 1'b0, 1'b0);
    advance(15);
    check_day("s1_t3", 3'd0, 6'd3, 1'b0);
    tick(1'b1, 1'b0, 1'b1);
    check_day("s1_late2", 3'd0, 6'd2, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_day("s1_late1", 3'd0, 6'd1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_day("s1_late0", 3'd0, 6'd0, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    check_day("s2_after_late", 3'd1, 6'd2, 1'b0);

    // Night entry from mid-S3 and return to S1
    advance(13);
    check_day("s3_mid", 3'd2, 6'd18, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("night_a", 3'd4, 6'd0, 3'b010, 3'b010, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("night_b", 3'd4, 6'd0, 3'b000, 3'b000, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    check("night_c", 3'd4, 6'd0, 3'b010, 3'b010, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    check_day("night_exit", 3'd0, 6'd18, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/traffic_light_ctrl.md
TRAFFIC_LIGHT_CTRL -- requirements
Module: traffic_light_ctrl

Interface
REQ-001 Parameter G1_SEC, default 29: road-1 green duration, in clk1h ticks (>=1).
REQ-002 Parameter G2_SEC, default 19: road-2 green duration, in ticks (>=1).
REQ-003 Parameter Y_SEC, default 3: yellow duration, in ticks (>=1), shared by both roads.
REQ-004 Parameter PED_SEC, default 5: green remaining after a pedestrian request, in ticks (>=1).
REQ-005 Parameter TW, default 6: width of time_left; 2^TW SHALL exceed max(G1_SEC, G2_SEC, Y_SEC).
REQ-006 clk1h  input  1: 1 Hz tick clock; all logic on its rising edge.
REQ-007 rst_n  input  1: synchronous, active-low reset.
REQ-008 night_mode  input  1: level request for flashing-yellow night operation.
REQ-009 ped_req  input  1: pedestrian button, level, sampled each tick.
REQ-010 led1  output  3: road-1 lamps {red,yellow,green}: 100 red, 010 yellow, 001 green.
REQ-011 led2  output  3: road-2 lamps, same encoding as led1.
REQ-012 time_left  output  TW: ticks remaining in the current phase, minus one.
REQ-013 state  output  3: current state code.
REQ-014 ped_pend  output  1: pedestrian request latched, not yet served.

Function
REQ-015 States: S1 (led1=100, led2=001), S2 (100/010), S3 (001/100), S4 (010/100), NIGHT.
REQ-016 led1/led2 SHALL be Moore decodes of the state register and update on the same edge as state.
REQ-017 In S1..S4, while time_left!=0, time_left SHALL decrement by 1 per tick.
REQ-018 When time_left==0, transitions SHALL be:
- S1->S2, loading Y_SEC-1.
- S2->S3, loading G1_SEC-1.
- S3->S4, loading Y_SEC-1.
- S4->S1, loading G2_SEC-1.
REQ-019 Each phase SHALL last exactly its parameter value in ticks; full cycle = G1_SEC+G2_SEC+2*Y_SEC ticks.
REQ-020 ped_pend SHALL set on any tick with ped_req=1 in S1..S4.
REQ-021 ped_pend SHALL clear on the S1->S2 and S3->S4 transitions, and on entry to NIGHT; clear wins over a simultaneous set.
REQ-022 In S1 or S3 with ped_pend=1 and time_left>PED_SEC-1, time_left SHALL load PED_SEC-1 instead of decrementing.
REQ-023 Otherwise ped_pend SHALL not alter timing; a request made during S2/S4 stays pending and is served in the next green phase.
REQ-024 In S1..S4, night_mode=1 SHALL force NIGHT on the next edge, overriding any S1..S4 transition; time_left loads 0.
REQ-025 In NIGHT, led1=led2 SHALL alternate between 010 and 000 each tick, starting with 010; time_left holds 0; ped_req ignored.
REQ-026 In NIGHT, night_mode=0 SHALL move to S1, loading G2_SEC-1, with led1=100, led2=001.
REQ-027 Unused state codes SHALL recover to S1, loading G2_SEC-1.

Reset
REQ-028 On rst_n=0 at a clk1h edge: state=S1, time_left=G2_SEC-1, led1=100, led2=001, ped_pend=0, night flash phase=0.
REQ-029 Reset SHALL take priority over night_mode and ped_req and be honoured mid-phase from any state.

Structure
REQ-030 Shared package traffic_pkg SHALL hold the state codes (S1=0, S2=1, S3=2, S4=3, NIGHT=4) and lamp constants RED=100, YEL=010, GRN=001, OFF=000.
REQ-031 Single module, no sub-module; the 1 Hz clock is supplied by the existing frequency divider outside this block.

Verification
REQ-032 Defaults, reset then 54 free ticks:
- S1 for 19 ticks, S2 for 3, S3 for 29, S4 for 3, then back to S1 with time_left=18.
REQ-033 ped_req pulse at S3 with time_left=20:
- Next tick time_left=4, ped_pend=1.
- S4 entered 5 ticks after the load; ped_pend=0 on entry.
REQ-034 ped_req held through S2:
- ped_pend stays 1.
- On entry to S3, time_left=28; next tick time_left=4.
REQ-035 ped_req at S1 with time_left=3 (<=4): countdown unchanged 3,2,1,0; S2 follows; ped_pend cleared.
REQ-036 night_mode=1 mid-S3:
- Next tick NIGHT; leds toggle 010,000,010 over three ticks.
- On deassert, S1 with time_left=18, led1=100, led2=001.
REQ-037 rst_n=0 during S4 with ped_pend=1: next edge S1, time_left=18, ped_pend=0.
